stopwatch_digit_counter: RTL
============================

STOPWATCH_DIGIT_COUNTER -- requirements
Module: stopwatch_digit_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of cascaded digits, legal range 1..8.
REQ-002 The block SHALL have parameter RADIX, default 9, maximum digit value: 9 for decimal, 15 for hex; other values are illegal and SHALL fail elaboration.
REQ-003 The block SHALL have port i_CLK, input, 1, the single clock.
REQ-004 The block SHALL have port i_RESET, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port i_CLK_EN, input, 1, count tick qualifier sampled on the rising edge of i_CLK.
REQ-006 The block SHALL have port i_SRST, input, 1, synchronous clear.
REQ-007 The block SHALL have ports i_START, i_STOP and i_LAP, input, 1 each, single-cycle command strobes.
REQ-008 The block SHALL have port o_DIGITS, output, 4*NUM_DIGITS, displayed digits with digit 0 (least significant) in bits [3:0].
REQ-009 The block SHALL have ports o_RUNNING, o_LAP_ACTIVE and o_OVERFLOW, output, 1 each, status flags.

Function
REQ-010 The FSM SHALL have states IDLE, RUN, PAUSE and LAP; counting SHALL occur only in RUN and LAP.
REQ-011 Transitions SHALL be: IDLE->RUN on i_START; RUN->PAUSE on i_STOP; PAUSE->RUN on i_START; RUN->LAP on i_LAP; LAP->RUN on i_LAP; LAP->PAUSE on i_STOP.
REQ-012 All other strobes SHALL be ignored, and i_START together with i_STOP in the same cycle SHALL cause no state change.
REQ-013 i_STOP together with i_LAP in the same cycle SHALL resolve as i_STOP.
REQ-014 On a cycle with i_CLK_EN=1 in a counting state, digit 0 SHALL increment, and digit k SHALL increment only when digits 0..k-1 all equal RADIX.
REQ-015 A digit equal to RADIX that increments SHALL wrap to 0, and a digit SHALL never hold a value greater than RADIX.
REQ-016 A tick with all digits at RADIX SHALL wrap every digit to 0 and set o_OVERFLOW, which stays set until reset or i_SRST.
REQ-017 The count SHALL be registered, so o_DIGITS reflects a tick on the next rising edge (1-cycle latency).
REQ-018 In LAP, o_DIGITS SHALL show a snapshot equal to the count value present on the cycle i_LAP was sampled (pre-increment), while the internal count keeps advancing.
REQ-019 In all states other than LAP, o_DIGITS SHALL show the live count.
REQ-020 o_RUNNING SHALL be 1 in RUN and LAP; o_LAP_ACTIVE SHALL be 1 in LAP only.
REQ-021 i_SRST SHALL take priority over all strobes and ticks in its cycle, forcing IDLE, a zero count, a zero snapshot and o_OVERFLOW=0.

Reset
REQ-022 Asserting i_RESET SHALL immediately force state IDLE, all digits 0, the snapshot 0, o_DIGITS=0, o_RUNNING=0, o_LAP_ACTIVE=0 and o_OVERFLOW=0, including mid-count and while in LAP.
REQ-023 The first tick SHALL be accepted on the first rising edge after i_RESET deasserts.

Configuration
REQ-024 With macro STOPWATCH_LAP_EN defined, the LAP state, the snapshot register and i_LAP behaviour SHALL be present.
REQ-025 Without STOPWATCH_LAP_EN, i_LAP SHALL be ignored, LAP SHALL be unreachable, no snapshot register SHALL exist, and o_LAP_ACTIVE SHALL be tied to 0.

Structure
REQ-026 Package stopwatch_pkg SHALL hold the FSM state enum, DIGIT_W=4, and the legal RADIX constants DEC_MAX=9 and HEX_MAX=15.
REQ-027 Sub-module stopwatch_digit_cell SHALL implement one digit with a 4-bit register, inputs carry-in, clear and enable, and output carry-out (asserted when value==RADIX and carry-in=1); it is instantiated NUM_DIGITS times via generate.

Verification
REQ-028 Scenario: NUM_DIGITS=4, RADIX=9, i_START, then 10 ticks -> o_DIGITS=0x0010 and o_RUNNING=1.
REQ-029 Scenario: preload 9999 via ticks, then 1 tick -> o_DIGITS=0x0000 and o_OVERFLOW=1; then i_SRST -> o_OVERFLOW=0 and state IDLE.
REQ-030 Scenario: RADIX=15, count 0x00FF then 1 tick -> o_DIGITS=0x0100.
REQ-031 Scenario: RUN at count 0x0042, i_LAP, 5 ticks -> o_DIGITS stays 0x0042; i_LAP again -> o_DIGITS=0x0047 live.
REQ-032 Scenario: i_START and i_STOP in the same cycle during RUN -> remains RUN; i_STOP plus i_LAP in LAP -> PAUSE and o_LAP_ACTIVE=0.
REQ-033 Scenario: i_RESET asserted asynchronously mid-count at 0x0123 -> all outputs 0 before the next clock edge; build without STOPWATCH_LAP_EN plus i_LAP -> no state change.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch digit counter.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DEC_MAX    = 9;
    localparam int unsigned HEX_MAX    = 15;
    localparam int unsigned MIN_DIGITS = 1;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_e;

    // Counting happens only while the watch is running (with or without a lap hold).
    function automatic logic is_counting(input sw_state_e s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_digit_cell.sv
// One stopwatch digit: a 4-bit register that advances when enabled and carried into,
// wrapping from RADIX back to 0 and producing a carry for the next digit.
module stopwatch_digit_cell
    import stopwatch_pkg::*;
#(
    parameter int unsigned RADIX = DEC_MAX
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic               carry_in,
    input  logic               clear,
    input  logic               enable,
    output logic               carry_out_c,
    output logic [DIGIT_W-1:0] value,
    output logic [DIGIT_W-1:0] next_value_c
);

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(RADIX);

    logic at_max_c;

    assign at_max_c    = (value == MAX_VAL);
    assign carry_out_c = at_max_c & carry_in;

    // Next digit value: clear wins, otherwise advance on an enabled carry-in.
    always_comb begin
        next_value_c = value;
        if (clear) begin
            next_value_c = '0;
        end else if (enable && carry_in) begin
            next_value_c = at_max_c ? '0 : value + DIGIT_W'(1);
        end
    end

    // Digit register.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            value <= '0;
        end else begin
            value <= next_value_c;
        end
    end

endmodule

// File: rtl/stopwatch_digit_counter.sv
// Stopwatch built from a cascade of digit cells with a start/stop/lap controller.
// Optional lap-hold display is compiled in with STOPWATCH_LAP_EN.
module stopwatch_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned RADIX      = DEC_MAX
) (
    input  logic                            i_CLK,
    input  logic                            i_RESET,
    input  logic                            i_CLK_EN,
    input  logic                            i_SRST,
    input  logic                            i_START,
    input  logic                            i_STOP,
    input  logic                            i_LAP,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   o_DIGITS,
    output logic                            o_RUNNING,
    output logic                            o_LAP_ACTIVE,
    output logic                            o_OVERFLOW
);

    localparam int unsigned CNT_W = DIGIT_W * NUM_DIGITS;

    // Reject configurations the digit cells cannot represent.
    if (!(RADIX == DEC_MAX || RADIX == HEX_MAX)) begin : g_bad_radix
        $error("stopwatch_digit_counter: RADIX=%0d must be 9 or 15", RADIX);
    end
    if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("stopwatch_digit_counter: NUM_DIGITS=%0d outside 1..8", NUM_DIGITS);
    end

    sw_state_e          state_q;
    sw_state_e          state_next_c;
    logic               tick_c;
    logic               wrap_c;
    logic               start_cmd_c;
    logic               stop_cmd_c;
    logic               lap_cmd_c;
    logic [NUM_DIGITS:0] carry_c;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_next_c;

    // Start and stop together cancel; stop overrides lap.
    assign start_cmd_c = i_START & ~i_STOP;
    assign stop_cmd_c  = i_STOP & ~i_START;
`ifdef STOPWATCH_LAP_EN
    assign lap_cmd_c   = i_LAP & ~i_STOP;
`else
    assign lap_cmd_c   = 1'b0;
`endif

    assign tick_c     = is_counting(state_q) & i_CLK_EN & ~i_SRST;
    assign carry_c[0] = tick_c;
    assign wrap_c     = carry_c[NUM_DIGITS];

    // Ripple-carry chain of digit cells, digit 0 least significant.
    for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
        stopwatch_digit_cell #(
            .RADIX (RADIX)
        ) u_cell (
            .i_CLK        (i_CLK),
            .i_RESET      (i_RESET),
            .carry_in     (carry_c[g]),
            .clear        (i_SRST),
            .enable       (tick_c),
            .carry_out_c  (carry_c[g+1]),
            .value        (count_q[g*DIGIT_W +: DIGIT_W]),
            .next_value_c (count_next_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Controller state register.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next_c;
        end
    end

    // Controller next-state: synchronous clear first, then command strobes.
    always_comb begin
        state_next_c = state_q;
        if (i_SRST) begin
            state_next_c = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_cmd_c) state_next_c = RUN;
                end
                RUN: begin
                    if (stop_cmd_c)     state_next_c = PAUSE;
                    else if (lap_cmd_c) state_next_c = LAP;
                end
                PAUSE: begin
                    if (start_cmd_c) state_next_c = RUN;
                end
                LAP: begin
                    if (stop_cmd_c)     state_next_c = PAUSE;
                    else if (lap_cmd_c) state_next_c = RUN;
                end
                default: state_next_c = IDLE;
            endcase
        end
    end

    // Running flag tracks the upcoming state; overflow is sticky until cleared.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            o_RUNNING  <= 1'b0;
            o_OVERFLOW <= 1'b0;
        end else begin
            o_RUNNING  <= is_counting(state_next_c);
            o_OVERFLOW <= ~i_SRST & (o_OVERFLOW | wrap_c);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [CNT_W-1:0] snap_q;
    logic [CNT_W-1:0] snap_next_c;
    logic [CNT_W-1:0] disp_next_c;

    // Snapshot holds the pre-tick count of the cycle that entered the lap hold.
    always_comb begin
        snap_next_c = snap_q;
        disp_next_c = count_next_c;
        if (i_SRST) begin
            snap_next_c = '0;
        end else if (state_next_c == LAP && state_q != LAP) begin
            snap_next_c = count_q;
        end
        if (state_next_c == LAP) begin
            disp_next_c = snap_next_c;
        end
    end

    // Snapshot, display and lap flag registers.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            snap_q       <= '0;
            o_DIGITS     <= '0;
            o_LAP_ACTIVE <= 1'b0;
        end else begin
            snap_q       <= snap_next_c;
            o_DIGITS     <= disp_next_c;
            o_LAP_ACTIVE <= (state_next_c == LAP);
        end
    end
`else
    logic [CNT_W:0] unused_sinks;

    // Without lap hold the display is the live count register itself.
    assign o_DIGITS     = count_q;
    assign o_LAP_ACTIVE = 1'b0;
    assign unused_sinks = {i_LAP, count_next_c};
`endif

endmodule
